// File: rtl/mlp_pkg.sv
// Shared constants and state type for the MLP accelerator result unload path.
package mlp_pkg;

    localparam int DW            = 16;
    localparam int ROWS          = 16;
    localparam int COLS          = 16;
    localparam int WORDS_PER_ROW = COLS / 2;
    localparam int ROW_W         = $clog2(ROWS);
    localparam int WORD_W        = $clog2(WORDS_PER_ROW);
    localparam int IDX_W         = $clog2(ROWS * COLS / 2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        DONE
    } unload_state_e;

endpackage

// File: rtl/result_unload_if.sv
// Row read port and output word stream between result_unload and its neighbours.
interface result_unload_if;
    import mlp_pkg::*;

    logic                     rd_en_o;
    logic [ROW_W-1:0]         rd_row_o;
    logic [COLS*DW-1:0]       rd_row_data_i;
    logic                     result_valid_o;
    logic                     result_ready_i;
    logic [2*DW-1:0]          result_payload_o;

    modport master (
        output rd_en_o,
        output rd_row_o,
        input  rd_row_data_i,
        output result_valid_o,
        input  result_ready_i,
        output result_payload_o
    );

    modport slave (
        input  rd_en_o,
        input  rd_row_o,
        output rd_row_data_i,
        input  result_valid_o,
        output result_ready_i,
        input  result_payload_o
    );

endinterface

// File: rtl/result_unload_counter.sv
// Generic enable-gated up counter with synchronous active-low clear.
module counter #(
    parameter int cnt_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [cnt_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/result_unload.sv
// Streams the result matrix row by row onto a 32-bit valid/ready port, two elements per word.
module result_unload
    import mlp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    result_unload_if.master bus
);

    unload_state_e      state;
    unload_state_e      state_next;
    logic [IDX_W-1:0]   idx;
    logic [ROW_W-1:0]   row;
    logic [WORD_W-1:0]  word;
    logic [COLS*DW-1:0] row_buf;
    logic               handshake;
    logic               cnt_rst_n;

    assign row       = idx[IDX_W-1 -: ROW_W];
    assign word      = idx[WORD_W-1:0];
    assign handshake = (state == SEND) && bus.result_ready_i;

    // A start accepted in IDLE also clears the word index so every stream begins at word 0.
    assign cnt_rst_n = rst_n && !((state == IDLE) && start_i);

    counter #(
        .cnt_WIDTH (IDX_W)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (cnt_rst_n),
        .en    (handshake),
        .count (idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_buf <= '0;
        end else if (state == WAIT) begin
            row_buf <= bus.rd_row_data_i;
        end
    end

    always_comb begin
        state_next           = state;
        bus.rd_en_o          = 1'b0;
        bus.rd_row_o         = '0;
        bus.result_valid_o   = 1'b0;
        bus.result_payload_o = '0;
        busy_o               = (state != IDLE);
        done_o               = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                bus.rd_en_o  = 1'b1;
                bus.rd_row_o = row;
                state_next   = WAIT;
            end
            WAIT: begin
                state_next = SEND;
            end
            SEND: begin
                bus.result_valid_o   = 1'b1;
                bus.result_payload_o = row_buf[32'(word) * (2*DW) +: 2*DW];
                // Leave after the last word of a row; the counter already points at the next row.
                if (handshake && (word == WORD_W'(WORDS_PER_ROW - 1))) begin
                    state_next = (row == ROW_W'(ROWS - 1)) ? DONE : FETCH;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_unload.sv
// Directed self-checking bench for result_unload with a one-cycle-latency row memory model.
module tb_result_unload;
    import mlp_pkg::*;

    logic clk;
    logic rst_n;
    logic start_i;
    logic busy_o;
    logic done_o;
    int   checks;
    int   errors;
    logic [31:0] got [128];

    result_unload_if bus ();

    result_unload dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [COLS*DW-1:0] row_data(input logic [ROW_W-1:0] r);
        logic [COLS*DW-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
            v[c*DW +: DW] = 16'(int'(r) * 16 + c);
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_word(input int w);
        int lo;
        lo = (w / 8) * 16 + 2 * (w % 8);
        return {16'(lo + 1), 16'(lo)};
    endfunction

    // Row memory answers one cycle after the read request and shows junk otherwise.
    always @(posedge clk) begin
        if (bus.rd_en_o) begin
            bus.rd_row_data_i <= row_data(bus.rd_row_o);
        end else begin
            bus.rd_row_data_i <= {8{32'hDEAD_BEEF}};
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic run_stream(input string tag, input bit rand_ready, input bit repulse,
                              input int stall_at, input int abort_at);
        int words, reads, dones, cyc, stall_cnt, done_cyc;
        bit data_ok, order_ok, stable_ok, stalled;
        logic [31:0] held;
        words = 0; reads = 0; dones = 0; stall_cnt = 0; done_cyc = 0;
        data_ok = 1; order_ok = 1; stable_ok = 1; stalled = 0; held = '0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        while (dones == 0 && cyc < 2000) begin
            if (abort_at >= 0 && words == abort_at) break;
            start_i = repulse && (cyc == 5 || cyc == 80);
            if (stall_at >= 0 && words == stall_at && stall_cnt < 20 && bus.result_valid_o) begin
                bus.result_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                bus.result_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus.rd_en_o) begin
                if (int'(bus.rd_row_o) != reads || words != reads * 8) order_ok = 0;
                reads++;
            end
            if (stalled && (!bus.result_valid_o || bus.result_payload_o !== held)) stable_ok = 0;
            stalled = bus.result_valid_o && !bus.result_ready_i;
            held    = bus.result_payload_o;
            if (bus.result_valid_o && bus.result_ready_i) begin
                if (words > 127 || bus.result_payload_o !== exp_word(words)) data_ok = 0;
                if (words <= 127) got[words] = bus.result_payload_o;
                words++;
            end
            if (done_o) begin
                dones++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        if (abort_at >= 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            check_output({tag, " reset flags"},
                         32'({bus.rd_en_o, bus.result_valid_o, busy_o, done_o, bus.rd_row_o}), 32'h0);
            check_output({tag, " reset payload"}, bus.result_payload_o, 32'h0);
            check_output({tag, " words before reset"}, 32'(words), 32'(abort_at));
            rst_n = 1'b1;
            repeat (30) begin
                if (done_o || busy_o) dones++;
                @(negedge clk);
            end
            check_output({tag, " no done after reset"}, 32'(dones), 32'h0);
        end else begin
            check_output({tag, " word count"}, 32'(words), 32'd128);
            check_output({tag, " read count"}, 32'(reads), 32'd16);
            check_output({tag, " done count"}, 32'(dones), 32'd1);
            check_output({tag, " data"}, 32'(data_ok), 32'd1);
            check_output({tag, " read order"}, 32'(order_ok), 32'd1);
            check_output({tag, " stall stable"}, 32'(stable_ok), 32'd1);
            if (!rand_ready && stall_at < 0) check_output({tag, " done cycle"}, 32'(done_cyc), 32'd161);
            if (stall_at >= 0) begin
                check_output({tag, " stall length"}, 32'(stall_cnt), 32'd20);
                check_output({tag, " done cycle"}, 32'(done_cyc), 32'd181);
            end
            check_output({tag, " idle after"}, 32'({busy_o, done_o, bus.result_valid_o}), 32'h0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start_i = 1'b0;
        bus.result_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset flags",
                     32'({bus.rd_en_o, bus.result_valid_o, busy_o, done_o, bus.rd_row_o}), 32'h0);
        check_output("reset payload", bus.result_payload_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_stream("full", 1'b0, 1'b0, -1, -1);
        check_output("full word 0", got[0], 32'h0001_0000);
        check_output("full word 8", got[8], 32'h0011_0010);
        check_output("full word 127", got[127], 32'h00FF_00FE);

        run_stream("random ready", 1'b1, 1'b0, -1, -1);
        run_stream("restart pulses", 1'b0, 1'b1, -1, -1);
        run_stream("abort", 1'b0, 1'b0, -1, 40);
        run_stream("after abort", 1'b0, 1'b0, -1, -1);
        check_output("after abort word 0", got[0], 32'h0001_0000);
        run_stream("stall", 1'b0, 1'b0, 31, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
